// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one dual-port BRAM between two kernel memory requesters. Port 0
// carries loads and port 1 carries stores. Loads and stores are arbitrated
// independently, each with its own 1-bit round-robin pointer.
//
// Handshake: a request transfers in the cycle where valid[i] and ready[i]
// are both 1. ready is combinational from the valid inputs and the pointer,
// and at most one ready bit per arbiter is 1. Load responses (rd_valid) have
// no backpressure and appear exactly one cycle after the load grant.
//
// Optional build macro: ARB_RAW_STALL_EN
//   When defined, a load whose address matches the store granted in the same
//   cycle is held off, so that it later returns the freshly written data.
//
// Ports (requester i occupies bits [i*W +: W] of packed vectors):
//   clk, rst                 clock, synchronous active-low reset
//   ld_valid/ld_ready/ld_addr  load request channel (2 requesters)
//   rd_valid/rd_data         load response channel
//   st_valid/st_ready/st_addr/st_data  store request channel
//   ce0/we0/address0/dout0/din0  BRAM port 0 (read-only use)
//   ce1/we1/address1/dout1   BRAM port 1 (write-only use)
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              ld_valid,
    output logic [1:0]              ld_ready,
    input  logic [2*ADDR_WIDTH-1:0] ld_addr,
    output logic [1:0]              rd_valid,
    output logic [2*DATA_WIDTH-1:0] rd_data,
    input  logic [1:0]              st_valid,
    output logic [1:0]              st_ready,
    input  logic [2*ADDR_WIDTH-1:0] st_addr,
    input  logic [2*DATA_WIDTH-1:0] st_data,
    output logic                    ce0,
    output logic                    we0,
    output logic [ADDR_WIDTH-1:0]   address0,
    output logic [DATA_WIDTH-1:0]   dout0,
    input  logic [DATA_WIDTH-1:0]   din0,
    output logic                    ce1,
    output logic                    we1,
    output logic [ADDR_WIDTH-1:0]   address1,
    output logic [DATA_WIDTH-1:0]   dout1
);

    // Round-robin pick between two requesters; ptr names the winner on a tie.
    function automatic logic [1:0] arb(input logic [1:0] v, input logic ptr);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return ptr ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    logic                  ld_ptr_q, ld_ptr_d;
    logic                  st_ptr_q, st_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_idx_q, rd_idx_d;

    logic [1:0]            ld_cand;
    logic [1:0]            ld_gnt;
    logic [1:0]            st_gnt;
    logic [ADDR_WIDTH-1:0] ld_sel_addr;
    logic [ADDR_WIDTH-1:0] st_sel_addr;
    logic [DATA_WIDTH-1:0] st_sel_data;
    logic                  raw_hit;

    always_comb begin
        ld_cand     = arb(ld_valid, ld_ptr_q);
        st_gnt      = rst ? arb(st_valid, st_ptr_q) : 2'b00;
        // Candidate addresses are muxed by the would-be winner so the RAW
        // compare can see the load address before the load grant exists.
        ld_sel_addr = ld_cand[1] ? ld_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : ld_addr[ADDR_WIDTH-1:0];
        st_sel_addr = st_gnt[1]  ? st_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : st_addr[ADDR_WIDTH-1:0];
        st_sel_data = st_gnt[1]  ? st_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : st_data[DATA_WIDTH-1:0];
    end

`ifdef ARB_RAW_STALL_EN
    // A load to the address being written this cycle waits; the pointer is
    // left alone so the stalled requester keeps its turn.
    assign raw_hit = (|st_gnt) && (|ld_cand) && (ld_sel_addr == st_sel_addr);
`else
    assign raw_hit = 1'b0;
`endif

    assign ld_gnt = (rst && !raw_hit) ? ld_cand : 2'b00;

    // Request-side outputs
    assign ld_ready = ld_gnt;
    assign st_ready = st_gnt;

    // BRAM port 0: loads only
    assign ce0      = |ld_gnt;
    assign we0      = 1'b0;
    assign address0 = ce0 ? ld_sel_addr : '0;
    assign dout0    = '0;

    // BRAM port 1: stores only
    assign ce1      = |st_gnt;
    assign we1      = ce1;
    assign address1 = ce1 ? st_sel_addr : '0;
    assign dout1    = ce1 ? st_sel_data : '0;

    // Load response: din0 is routed to the requester that issued last cycle.
    always_comb begin
        rd_valid = 2'b00;
        rd_data  = '0;
        if (rd_pend_q) begin
            if (rd_idx_q) begin
                rd_valid                           = 2'b10;
                rd_data[2*DATA_WIDTH-1:DATA_WIDTH] = din0;
            end else begin
                rd_valid                  = 2'b01;
                rd_data[DATA_WIDTH-1:0]   = din0;
            end
        end
    end

    // Next state: after a grant the pointer favours the other requester.
    always_comb begin
        ld_ptr_d  = (|ld_gnt) ? ld_gnt[0] : ld_ptr_q;
        st_ptr_d  = (|st_gnt) ? st_gnt[0] : st_ptr_q;
        rd_pend_d = |ld_gnt;
        rd_idx_d  = (|ld_gnt) ? ld_gnt[1] : rd_idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_ptr_q  <= 1'b0;
            st_ptr_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= 1'b0;
        end else begin
            ld_ptr_q  <= ld_ptr_d;
            st_ptr_q  <= st_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed, table-driven bench for bram_port_arbiter with a small BRAM model
// attached to both ports. Each table row is one clock cycle: inputs are
// driven after the falling edge, and outputs are compared 1 time unit later,
// well before the next rising edge. Row expectations for rd_valid/rd_data
// reflect the load granted in the previous row.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]      ld_valid = '0;
    logic [1:0]      ld_ready;
    logic [2*AW-1:0] ld_addr  = '0;
    logic [1:0]      rd_valid;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      st_valid = '0;
    logic [1:0]      st_ready;
    logic [2*AW-1:0] st_addr  = '0;
    logic [2*DW-1:0] st_data  = '0;
    logic            ce0, we0, ce1, we1;
    logic [AW-1:0]   address0, address1;
    logic [DW-1:0]   dout0, dout1;
    logic [DW-1:0]   din0;

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0), .din0(din0),
        .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1)
    );

    // ---------------- BRAM model (read-first on collision) ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ce1 && we1) mem[address1] <= dout1;
        if (ce0) din0 <= mem[address0];
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            rst;
        logic [1:0]      ld_v;
        logic [2*AW-1:0] ld_a;
        logic [1:0]      st_v;
        logic [2*AW-1:0] st_a;
        logic [2*DW-1:0] st_d;
        logic [1:0]      e_ldr;
        logic [1:0]      e_str;
        logic            e_ce0;
        logic [AW-1:0]   e_a0;
        logic            e_ce1;
        logic [AW-1:0]   e_a1;
        logic [DW-1:0]   e_d1;
        logic [1:0]      e_rdv;
        logic [2*DW-1:0] e_rdd;
    } vec_t;

    function automatic logic [2*AW-1:0] pa(input int a1, input int a0);
        logic [AW-1:0] h, l;
        h = AW'(a1);
        l = AW'(a0);
        return {h, l};
    endfunction

    task automatic drive(input logic r, input logic [1:0] lv, input logic [2*AW-1:0] la,
                         input logic [1:0] sv, input logic [2*AW-1:0] sa,
                         input logic [2*DW-1:0] sd);
        @(negedge clk);
        rst      = r;
        ld_valid = lv;
        ld_addr  = la;
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        check({p, ".ld_ready"}, 32'(ld_ready), 32'(v.e_ldr));
        check({p, ".st_ready"}, 32'(st_ready), 32'(v.e_str));
        check({p, ".ce0"},      32'(ce0),      32'(v.e_ce0));
        check({p, ".address0"}, 32'(address0), 32'(v.e_a0));
        check({p, ".ce1"},      32'(ce1),      32'(v.e_ce1));
        check({p, ".we1"},      32'(we1),      32'(v.e_ce1));
        check({p, ".address1"}, 32'(address1), 32'(v.e_a1));
        check({p, ".dout1"},    32'(dout1),    32'(v.e_d1));
        check({p, ".rd_valid"}, 32'(rd_valid), 32'(v.e_rdv));
        check({p, ".rd_data"},  32'(rd_data),  32'(v.e_rdd));
        check({p, ".we0"},      32'(we0),      32'd0);
        check({p, ".dout0"},    32'(dout0),    32'd0);
    endtask

    task automatic preload(input int a, input int d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = DW'(d);
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        // rst  ld_v  ld_a          st_v  st_a           st_d
        //      e_ldr e_str e_ce0 e_a0 e_ce1 e_a1 e_d1  e_rdv e_rdd
        // Reset: everything held off even with requests present.
        vecs[0]  = '{1'b0, 2'b01, pa(0, 5),  2'b11, pa(11, 10), 16'hB2A1,
                     2'b00, 2'b00, 1'b0, 7'd0,  1'b0, 7'd0,  8'h00, 2'b00, 16'h0000};
        // Single load from requester 0, first cycle out of reset.
        vecs[1]  = '{1'b1, 2'b01, pa(0, 5),  2'b00, '0, '0,
                     2'b01, 2'b00, 1'b1, 7'd5,  1'b0, 7'd0,  8'h00, 2'b00, 16'h0000};
        vecs[2]  = '{1'b1, 2'b00, '0,        2'b00, '0, '0,
                     2'b00, 2'b00, 1'b0, 7'd0,  1'b0, 7'd0,  8'h00, 2'b01, 16'h003C};
        // Reset again with loads and stores requested: no grants, no ports.
        vecs[3]  = '{1'b0, 2'b01, pa(0, 5),  2'b01, pa(0, 9),   16'h0077,
                     2'b00, 2'b00, 1'b0, 7'd0,  1'b0, 7'd0,  8'h00, 2'b00, 16'h0000};
        // Load contention after reset: grants alternate 0,1,0,1.
        vecs[4]  = '{1'b1, 2'b11, pa(21, 20), 2'b00, '0, '0,
                     2'b01, 2'b00, 1'b1, 7'd20, 1'b0, 7'd0,  8'h00, 2'b00, 16'h0000};
        vecs[5]  = '{1'b1, 2'b11, pa(21, 20), 2'b00, '0, '0,
                     2'b10, 2'b00, 1'b1, 7'd21, 1'b0, 7'd0,  8'h00, 2'b01, 16'h0011};
        vecs[6]  = '{1'b1, 2'b11, pa(21, 20), 2'b00, '0, '0,
                     2'b01, 2'b00, 1'b1, 7'd20, 1'b0, 7'd0,  8'h00, 2'b10, 16'h2200};
        vecs[7]  = '{1'b1, 2'b11, pa(21, 20), 2'b00, '0, '0,
                     2'b10, 2'b00, 1'b1, 7'd21, 1'b0, 7'd0,  8'h00, 2'b01, 16'h0011};
        vecs[8]  = '{1'b1, 2'b00, '0,        2'b00, '0, '0,
                     2'b00, 2'b00, 1'b0, 7'd0,  1'b0, 7'd0,  8'h00, 2'b10, 16'h2200};
        // Store contention: requester 0 then requester 1.
        vecs[9]  = '{1'b1, 2'b00, '0,        2'b11, pa(11, 10), 16'hB2A1,
                     2'b00, 2'b01, 1'b0, 7'd0,  1'b1, 7'd10, 8'hA1, 2'b00, 16'h0000};
        vecs[10] = '{1'b1, 2'b00, '0,        2'b11, pa(11, 10), 16'hB2A1,
                     2'b00, 2'b10, 1'b0, 7'd0,  1'b1, 7'd11, 8'hB2, 2'b00, 16'h0000};
        vecs[11] = '{1'b1, 2'b00, '0,        2'b00, '0, '0,
                     2'b00, 2'b00, 1'b0, 7'd0,  1'b0, 7'd0,  8'h00, 2'b00, 16'h0000};
        // Read back the stored words.
        vecs[12] = '{1'b1, 2'b01, pa(0, 10), 2'b00, '0, '0,
                     2'b01, 2'b00, 1'b1, 7'd10, 1'b0, 7'd0,  8'h00, 2'b00, 16'h0000};
        vecs[13] = '{1'b1, 2'b10, pa(11, 0), 2'b00, '0, '0,
                     2'b10, 2'b00, 1'b1, 7'd11, 1'b0, 7'd0,  8'h00, 2'b01, 16'h00A1};
        vecs[14] = '{1'b1, 2'b00, '0,        2'b00, '0, '0,
                     2'b00, 2'b00, 1'b0, 7'd0,  1'b0, 7'd0,  8'h00, 2'b10, 16'hB200};
        // Requester 1 loads 7 and stores 8 in the same cycle.
        vecs[15] = '{1'b1, 2'b10, pa(7, 0),  2'b10, pa(8, 0),  16'h9900,
                     2'b10, 2'b10, 1'b1, 7'd7,  1'b1, 7'd8,  8'h99, 2'b00, 16'h0000};
        vecs[16] = '{1'b1, 2'b00, '0,        2'b00, '0, '0,
                     2'b00, 2'b00, 1'b0, 7'd0,  1'b0, 7'd0,  8'h00, 2'b10, 16'h7700};

        // Hold reset while the BRAM model is seeded.
        rst = 1'b0;
        preload(5, 8'h3C);
        preload(20, 8'h11);
        preload(21, 8'h22);
        preload(7, 8'h77);
        preload(3, 8'h00);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].ld_v, vecs[i].ld_a,
                  vecs[i].st_v, vecs[i].st_a, vecs[i].st_d);
            check_vec(i, vecs[i]);
        end

        // RAW collision: requester 0 stores 0x55 to 3, requester 1 loads 3.
        drive(1'b1, 2'b10, pa(3, 0), 2'b01, pa(0, 3), 16'h0055);
        check("raw.st_ready", 32'(st_ready), 32'h1);
        check("raw.address1", 32'(address1), 32'd3);
`ifdef ARB_RAW_STALL_EN
        check("raw.ld_ready_stall", 32'(ld_ready), 32'h0);
        check("raw.ce0_stall", 32'(ce0), 32'h0);
        drive(1'b1, 2'b10, pa(3, 0), 2'b00, '0, '0);
        check("raw.ld_ready_retry", 32'(ld_ready), 32'h2);
        check("raw.address0", 32'(address0), 32'd3);
        drive(1'b1, 2'b00, '0, 2'b00, '0, '0);
        check("raw.rd_valid", 32'(rd_valid), 32'h2);
        check("raw.rd_data", 32'(rd_data), 32'h5500);
`else
        check("raw.ld_ready_same", 32'(ld_ready), 32'h2);
        check("raw.address0", 32'(address0), 32'd3);
        drive(1'b1, 2'b00, '0, 2'b00, '0, '0);
        check("raw.rd_valid", 32'(rd_valid), 32'h2);
`endif

        // Reset with a load in flight: no response in the following cycle,
        // and the load pointer is back at requester 0 afterwards.
        drive(1'b1, 2'b10, pa(7, 0), 2'b00, '0, '0);
        check("mid.ld_ready", 32'(ld_ready), 32'h2);
        drive(1'b0, 2'b11, pa(7, 5), 2'b11, pa(9, 8), 16'h1234);
        check("mid.ld_ready_rst", 32'(ld_ready), 32'h0);
        check("mid.st_ready_rst", 32'(st_ready), 32'h0);
        check("mid.ce0_rst", 32'(ce0), 32'h0);
        check("mid.ce1_rst", 32'(ce1), 32'h0);
        drive(1'b1, 2'b11, pa(7, 5), 2'b00, '0, '0);
        check("mid.rd_valid_dropped", 32'(rd_valid), 32'h0);
        check("mid.ptr_reset_grant", 32'(ld_ready), 32'h1);
        drive(1'b1, 2'b00, '0, 2'b00, '0, '0);
        check("mid.rd_after", 32'(rd_data), 32'h003C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
